rib_rr_arbiter: RTL and testbench
=================================

// Module: rib_rr_arbiter
// PURPOSE
//  Shares one memory/peripheral slave port between NUM_M masters: core fetch, core EX load/store, JTAG, DMA.
//  Arbitrates each transaction, holds the grant until slave ack or timeout, and returns per-master stall flags.
//  Stall flags feed the core's bus-hold input. Sits between the core/JTAG masters and the slave decode.
// PARAMETERS
//  NUM_M    4    number of masters (2..8)
//  AW       32   address width
//  DW       32   data width
//  PRIO_M   0    master index with fixed top priority (JTAG); all others round-robin
//  TIMEOUT  255  max BUSY cycles waiting for s_ack_i before error-ack (1..65535)
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active high
//  m_req_i      in   NUM_M     per-master request; held with we/addr/wdata stable until m_ack_o
//  m_we_i       in   NUM_M     per-master write enable
//  m_addr_i     in   NUM_M*AW  packed addresses, master i at [i*AW +: AW]
//  m_wdata_i    in   NUM_M*DW  packed write data
//  m_rdata_o    out  DW        read data, valid with m_ack_o (shared by all masters)
//  m_ack_o      out  NUM_M     one-hot completion pulse
//  m_err_o      out  1         pulses with m_ack_o on timeout completion
//  m_stall_o    out  NUM_M     m_req_i[i] & ~m_ack_o[i] (combinational)
//  s_req_o      out  1         slave request
//  s_we_o       out  1         slave write enable
//  s_addr_o     out  AW        slave address
//  s_wdata_o    out  DW        slave write data
//  s_rdata_i    in   DW        slave read data
//  s_ack_i      in   1         slave completion, one cycle
//  gnt_id_o     out  3         index of current owner, valid in BUSY
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; rr_ptr=NUM_M-1 (so master 0 wins first RR); tmo_cnt=0.
//    All outputs 0, including during a transaction cut off by reset; no ack issued.
//  FSM IDLE:
//    If |m_req_i, pick the winner and latch it into gnt.
//    Winner = PRIO_M if it is requesting; otherwise the first requester scanning rr_ptr+1, rr_ptr+2, ... mod NUM_M.
//    Go to BUSY with tmo_cnt=0. No requests -> stay IDLE.
//  FSM BUSY:
//    s_req_o=m_req_i[gnt]; s_we_o/s_addr_o/s_wdata_o muxed combinationally from master gnt.
//    s_ack_i=1: m_ack_o[gnt]=1 and m_rdata_o=s_rdata_i the same cycle; rr_ptr<=gnt (skipped when gnt==PRIO_M); ->IDLE.
//    tmo_cnt==TIMEOUT-1 without ack: m_ack_o[gnt]=1, m_err_o=1, m_rdata_o=0; rr_ptr<=gnt; ->IDLE.
//    Ack and timeout in the same cycle: ack wins and m_err_o=0.
//    m_req_i[gnt] drops before ack (protocol violation): abort; s_req_o=0 that cycle; no ack; rr_ptr unchanged; ->IDLE.
//    Otherwise tmo_cnt increments; it saturates and does not wrap.
//  Timing:
//    Minimum latency is 2 cycles: arbitrate in cycle 0, slave request in cycle 1, ack combinationally in cycle 1 if s_ack_i.
//    One IDLE turnaround cycle between transactions; peak throughput is 1 transfer per 2 cycles.
//  Outside BUSY: s_* outputs are 0, m_rdata_o=0, m_ack_o=0.
//  PRIO_M may starve the others by design; RR masters are never starved by one another.
//  A request arriving during BUSY waits; m_stall_o is high meanwhile.
//  Width: tmo_cnt is 16 bits; gnt_id_o is zero-extended to 3 bits.
// STRUCTURE
//  defines.v gains:
//    `RibStateIdle / `RibStateBusy encodings.
//    `RibMstJtag / `RibMstEx / `RibMstPc / `RibMstDma index constants.
//    Reuse the existing `MemAddrBus / `MemBus widths.
//  One sub-module, rib_rr_pick: combinational. Takes req vector, rr_ptr and PRIO_M; returns a winner index and a valid bit.
//  Top holds the FSM, gnt, rr_ptr, tmo_cnt and the output muxes.
// TESTING
//  Single read:
//    m_req_i=4'b0100, addr=0x1000_0004; s_ack_i in the 2nd BUSY cycle with s_rdata_i=0xDEADBEEF.
//    -> m_ack_o=4'b0100, m_rdata_o=0xDEADBEEF; m_stall_o[2] high for 2 cycles.
//  Round-robin:
//    Masters 1,2,3 request continuously; slave acks immediately.
//    -> grant order 1,2,3,1,2,3; one IDLE cycle between grants.
//  Priority:
//    Master 0 (PRIO_M) raises req while master 2 is BUSY.
//    -> master 2 completes; master 0 is granted next ahead of 1 and 3; rr_ptr stays 2.
//  Timeout:
//    TIMEOUT=8, slave never acks.
//    -> m_ack_o and m_err_o pulse on the 8th BUSY cycle with m_rdata_o=0; the next requester is then served.
//  Ack and timeout coincide:
//    s_ack_i on cycle 8 with TIMEOUT=8 -> m_err_o=0 and data returned.
//  Reset mid-transaction:
//    rst=1 during BUSY -> all outputs 0 next cycle, no ack; after release, master 0 wins the first RR.

Source files
------------

// File: rtl/rib_rr_arbiter_pkg.sv
// Shared types and constants for the bus arbiter: FSM encoding, master indices,
// counter widths and the round-robin index helper.
package rib_rr_arbiter_pkg;

  typedef enum logic {
    RIB_STATE_IDLE = 1'b0,
    RIB_STATE_BUSY = 1'b1
  } rib_state_e;

  localparam int RIB_MST_JTAG = 0;
  localparam int RIB_MST_EX   = 1;
  localparam int RIB_MST_PC   = 2;
  localparam int RIB_MST_DMA  = 3;

  localparam int RIB_ID_W  = 3;
  localparam int RIB_TMO_W = 16;

  // Index k positions after ptr, wrapped into 0..n-1.
  function automatic logic [RIB_ID_W-1:0] rr_next(input logic [RIB_ID_W-1:0] ptr,
                                                  input int k, input int n);
    return RIB_ID_W'((int'(ptr) + k) % n);
  endfunction

endpackage

// File: rtl/rib_rr_arbiter_pick.sv
// Combinational winner selection: fixed-priority master first, otherwise the
// first requester after rr_ptr in circular order.
module rib_rr_arbiter_pick
  import rib_rr_arbiter_pkg::*;
#(
  parameter int NUM_M  = 4,
  parameter int PRIO_M = 0
) (
  input  logic [NUM_M-1:0]    req,
  input  logic [RIB_ID_W-1:0] rr_ptr,
  output logic [RIB_ID_W-1:0] win,
  output logic                valid
);

  logic [7:0]          req8;
  logic [RIB_ID_W-1:0] idx;

  assign req8 = 8'(req);

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    if (req[PRIO_M]) begin
      win   = RIB_ID_W'(PRIO_M);
      valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_M; k++) begin
        idx = rr_next(rr_ptr, k, NUM_M);
        if (!valid && req8[idx]) begin
          win   = idx;
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Shares one slave port between NUM_M masters; holds the grant until slave ack,
// timeout (error completion) or requester withdrawal.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int PRIO_M  = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  output logic [DW-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic                m_err_o,
  output logic [NUM_M-1:0]    m_stall_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic [DW-1:0]       s_rdata_i,
  input  logic                s_ack_i,
  output logic [2:0]          gnt_id_o
);

  localparam logic [RIB_TMO_W-1:0] TMO_LAST = RIB_TMO_W'(TIMEOUT - 1);
  localparam logic [RIB_ID_W-1:0]  PRIO_ID  = RIB_ID_W'(PRIO_M);

  rib_state_e           state, state_d;
  logic [RIB_ID_W-1:0]  gnt, rr_ptr, pick_win;
  logic [RIB_TMO_W-1:0] tmo_cnt;
  logic                 pick_valid, ack_g, rr_load;
  logic                 req_g, we_g;
  logic [AW-1:0]        addr_g;
  logic [DW-1:0]        wdata_g;

  rib_rr_arbiter_pick #(.NUM_M(NUM_M), .PRIO_M(PRIO_M)) u_pick (
    .req    (m_req_i),
    .rr_ptr (rr_ptr),
    .win    (pick_win),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RIB_STATE_IDLE;
      gnt     <= '0;
      rr_ptr  <= RIB_ID_W'(NUM_M - 1);
      tmo_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == RIB_STATE_IDLE && pick_valid) begin
        gnt     <= pick_win;
        tmo_cnt <= '0;
      end else if (state == RIB_STATE_BUSY && tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (rr_load) rr_ptr <= gnt;
    end
  end

  always_comb begin
    req_g   = 1'b0;
    we_g    = 1'b0;
    addr_g  = '0;
    wdata_g = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt == RIB_ID_W'(i)) begin
        req_g   = m_req_i[i];
        we_g    = m_we_i[i];
        addr_g  = m_addr_i[i*AW +: AW];
        wdata_g = m_wdata_i[i*DW +: DW];
      end
    end
  end

  // Outputs are forced quiet while rst is asserted so a cut-off transfer never acks.
  always_comb begin
    state_d   = state;
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    m_rdata_o = '0;
    m_err_o   = 1'b0;
    gnt_id_o  = '0;
    ack_g     = 1'b0;
    rr_load   = 1'b0;
    if (!rst) begin
      case (state)
        RIB_STATE_IDLE: begin
          if (pick_valid) state_d = RIB_STATE_BUSY;
        end
        RIB_STATE_BUSY: begin
          gnt_id_o  = gnt;
          s_we_o    = we_g;
          s_addr_o  = addr_g;
          s_wdata_o = wdata_g;
          if (!req_g) begin
            state_d = RIB_STATE_IDLE;
          end else begin
            s_req_o = 1'b1;
            if (s_ack_i) begin
              ack_g     = 1'b1;
              m_rdata_o = s_rdata_i;
              rr_load   = (gnt != PRIO_ID);
              state_d   = RIB_STATE_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
              ack_g   = 1'b1;
              m_err_o = 1'b1;
              rr_load = 1'b1;
              state_d = RIB_STATE_IDLE;
            end
          end
        end
        default: state_d = RIB_STATE_IDLE;
      endcase
    end
  end

  always_comb begin
    m_ack_o = '0;
    for (int i = 0; i < NUM_M; i++) m_ack_o[i] = ack_g && (gnt == RIB_ID_W'(i));
  end

  assign m_stall_o = m_req_i & ~m_ack_o;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed cycle-by-cycle bench for rib_rr_arbiter with TIMEOUT=8.
module tb_rib_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req_i, m_we_i, m_ack_o, m_stall_o;
  logic [127:0] m_addr_i, m_wdata_i;
  logic [31:0]  m_rdata_o, s_addr_o, s_wdata_o, s_rdata_i;
  logic         m_err_o, s_req_o, s_we_o, s_ack_i;
  logic [2:0]   gnt_id_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] addr_tab [4] = '{32'h2000_0000, 32'h3000_0010, 32'h1000_0004, 32'h4000_0020};
  logic [31:0] wdata_tab[4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
  logic [3:0]  we_pat = 4'b1010;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic [31:0] rdata;
    logic [3:0]  e_ack;
    logic        e_err;
    logic        e_sreq;
    logic [2:0]  e_gnt;
    logic [31:0] e_rdata;
    logic [3:0]  e_stall;
  } vec_t;

  vec_t vq[$];

  rib_rr_arbiter #(.NUM_M(4), .AW(32), .DW(32), .PRIO_M(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_stall_o(m_stall_o), .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .gnt_id_o(gnt_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] req, input logic ack, input logic [31:0] rd,
                     input logic [3:0] e_ack, input logic e_err, input logic e_sreq,
                     input logic [2:0] e_gnt, input logic [31:0] e_rd, input logic [3:0] e_stall);
    vq.push_back('{r, req, ack, rd, e_ack, e_err, e_sreq, e_gnt, e_rd, e_stall});
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst       = v.rst;
    m_req_i   = v.req;
    s_ack_i   = v.ack;
    s_rdata_i = v.rdata;
    #3;
    chk({tag, ".ack"},   32'(m_ack_o),   32'(v.e_ack));
    chk({tag, ".err"},   32'(m_err_o),   32'(v.e_err));
    chk({tag, ".sreq"},  32'(s_req_o),   32'(v.e_sreq));
    chk({tag, ".gnt"},   32'(gnt_id_o),  32'(v.e_gnt));
    chk({tag, ".rdata"}, m_rdata_o,      v.e_rdata);
    chk({tag, ".stall"}, 32'(m_stall_o), 32'(v.e_stall));
    if (v.e_sreq) begin
      chk({tag, ".saddr"},  s_addr_o,        addr_tab[v.e_gnt]);
      chk({tag, ".swdata"}, s_wdata_o,       wdata_tab[v.e_gnt]);
      chk({tag, ".swe"},    32'(s_we_o),     32'(we_pat[v.e_gnt]));
    end
  endtask

  task automatic hand(input logic r, input logic [3:0] req, input logic ack, input logic [31:0] rd,
                      input logic [3:0] e_ack, input logic e_err, input logic e_sreq,
                      input logic [2:0] e_gnt, input logic [31:0] e_rd, input logic [3:0] e_stall,
                      input string tag);
    vec_t v;
    v = '{r, req, ack, rd, e_ack, e_err, e_sreq, e_gnt, e_rd, e_stall};
    apply(v, tag);
  endtask

  initial begin
    rst = 1'b1; m_req_i = '0; s_ack_i = 1'b0; s_rdata_i = '0;
    m_we_i = we_pat;
    for (int i = 0; i < 4; i++) begin
      m_addr_i[i*32 +: 32]  = addr_tab[i];
      m_wdata_i[i*32 +: 32] = wdata_tab[i];
    end

    // reset
    add(1, 4'b0000, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0, 4'b0000);
    // round-robin 1,2,3,1,2,3 with immediate acks
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b1110, 1, 32'h101, 4'b0000, 0, 0, 0, 32'h0,   4'b1110);
      add(0, 4'b1110, 1, 32'h101, 4'b0010, 0, 1, 1, 32'h101, 4'b1100);
      add(0, 4'b1110, 1, 32'h102, 4'b0000, 0, 0, 0, 32'h0,   4'b1110);
      add(0, 4'b1110, 1, 32'h102, 4'b0100, 0, 1, 2, 32'h102, 4'b1010);
      add(0, 4'b1110, 1, 32'h103, 4'b0000, 0, 0, 0, 32'h0,   4'b1110);
      add(0, 4'b1110, 1, 32'h103, 4'b1000, 0, 1, 3, 32'h103, 4'b0110);
    end
    add(0, 4'b0000, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0, 4'b0000);
    // single read by master 2, ack on the 2nd BUSY cycle
    add(0, 4'b0100, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        4'b0100);
    add(0, 4'b0100, 0, 32'h0,        4'b0000, 0, 1, 2, 32'h0,        4'b0100);
    add(0, 4'b0100, 1, 32'hDEADBEEF, 4'b0100, 0, 1, 2, 32'hDEADBEEF, 4'b0000);
    add(0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        4'b0000);
    // priority master 0 arrives while master 2 is busy; rr_ptr must stay at 2
    add(0, 4'b0100, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b0100);
    add(0, 4'b1111, 0, 32'h0,  4'b0000, 0, 1, 2, 32'h0,  4'b1111);
    add(0, 4'b1111, 1, 32'h22, 4'b0100, 0, 1, 2, 32'h22, 4'b1011);
    add(0, 4'b1011, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b1011);
    add(0, 4'b1011, 1, 32'h23, 4'b0001, 0, 1, 0, 32'h23, 4'b1010);
    add(0, 4'b1010, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b1010);
    add(0, 4'b1010, 1, 32'h24, 4'b1000, 0, 1, 3, 32'h24, 4'b0010);
    add(0, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b0000);
    // timeout on master 1, then master 3 served
    add(0, 4'b1010, 0, 32'hBAD0BAD0, 4'b0000, 0, 0, 0, 32'h0, 4'b1010);
    for (int c = 1; c < 8; c++)
      add(0, 4'b1010, 0, 32'hBAD0BAD0, 4'b0000, 0, 1, 1, 32'h0, 4'b1010);
    add(0, 4'b1010, 0, 32'hBAD0BAD0, 4'b0010, 1, 1, 1, 32'h0, 4'b1000);
    add(0, 4'b1000, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b1000);
    add(0, 4'b1000, 1, 32'h33, 4'b1000, 0, 1, 3, 32'h33, 4'b0000);
    add(0, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b0000);

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // ack coincides with the timeout cycle: data returned, no error
    hand(0, 4'b0010, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0, 4'b0010, "coin.idle");
    for (int c = 1; c < 8; c++)
      hand(0, 4'b0010, 0, 32'h0, 4'b0000, 0, 1, 1, 32'h0, 4'b0010, $sformatf("coin.b%0d", c));
    hand(0, 4'b0010, 1, 32'h5A5A5A5A, 4'b0010, 0, 1, 1, 32'h5A5A5A5A, 4'b0000, "coin.b8");
    hand(0, 4'b0000, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0, 4'b0000, "coin.end");

    // reset during BUSY: no ack, quiet outputs, rr_ptr back to NUM_M-1
    hand(0, 4'b0100, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,  4'b0100, "rst.idle");
    hand(0, 4'b0100, 0, 32'h0,        4'b0000, 0, 1, 2, 32'h0,  4'b0100, "rst.busy");
    hand(1, 4'b0100, 1, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 32'h0,  4'b0100, "rst.hit");
    hand(0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,  4'b0000, "rst.after");
    hand(0, 4'b1110, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,  4'b1110, "rst.arb");
    hand(0, 4'b1110, 1, 32'h77,       4'b0010, 0, 1, 1, 32'h77, 4'b1100, "rst.first");
    hand(0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,  4'b0000, "rst.end");

    // requester withdraws mid-transfer: abort, no ack, rr_ptr unchanged
    hand(0, 4'b1000, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b1000, "abt.idle");
    hand(0, 4'b1000, 0, 32'h0,  4'b0000, 0, 1, 3, 32'h0,  4'b1000, "abt.busy");
    hand(0, 4'b0000, 1, 32'h99, 4'b0000, 0, 0, 3, 32'h0,  4'b0000, "abt.drop");
    hand(0, 4'b1010, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b1010, "abt.arb");
    hand(0, 4'b1010, 1, 32'hAB, 4'b1000, 0, 1, 3, 32'hAB, 4'b0010, "abt.next");
    hand(0, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 0, 32'h0,  4'b0000, "abt.end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
